// File: rtl/divider_8_by_4_bit.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, start/busy/done handshake.
// Define DIVIDER_RADIX4_EN to retire two quotient bits per DIVIDE cycle instead of one.
module divider_8_by_4_bit (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       Start_In,
    input  logic [7:0] Dividend_In,
    input  logic [3:0] Divisor_In,
    output logic       Busy_Out,
    output logic       Done_Out,
    output logic [7:0] Quotient_Out,
    output logic [3:0] Remainder_Out,
    output logic       Divide_By_Zero_Out
);

`ifdef DIVIDER_RADIX4_EN
    localparam int unsigned STEPS = 2;
`else
    localparam int unsigned STEPS = 1;
`endif
    localparam logic [2:0] LAST_ITER = 3'(8 / STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] dvd_sr;
    logic [7:0] quo_sr;
    logic [3:0] dvs;
    logic [4:0] prem;
    logic [2:0] iter;
    logic       dbz_pend;

    logic [7:0] dvd_step;
    logic [7:0] quo_step;
    logic [4:0] prem_step;

    // One or two chained restoring steps per cycle.
    always_comb begin
        dvd_step  = dvd_sr;
        quo_step  = quo_sr;
        prem_step = prem;
        for (int unsigned i = 0; i < STEPS; i++) begin
            prem_step = {prem_step[3:0], dvd_step[7]};
            dvd_step  = {dvd_step[6:0], 1'b0};
            if (prem_step >= {1'b0, dvs}) begin
                prem_step = prem_step - {1'b0, dvs};
                quo_step  = {quo_step[6:0], 1'b1};
            end else begin
                quo_step  = {quo_step[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start_In) state_nxt = DIVIDE;
            DIVIDE:  if (dbz_pend || iter == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy_Out = (state != IDLE);
    assign Done_Out = (state == DONE);

    // A zero divisor spends one DIVIDE cycle so its results land one edge after accept.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state              <= IDLE;
            dvd_sr             <= '0;
            quo_sr             <= '0;
            dvs                <= '0;
            prem               <= '0;
            iter               <= '0;
            dbz_pend           <= 1'b0;
            Quotient_Out       <= '0;
            Remainder_Out      <= '0;
            Divide_By_Zero_Out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Start_In) begin
                        dvd_sr   <= Dividend_In;
                        dvs      <= Divisor_In;
                        quo_sr   <= '0;
                        prem     <= '0;
                        iter     <= '0;
                        dbz_pend <= (Divisor_In == 4'd0);
                    end
                end
                DIVIDE: begin
                    if (dbz_pend) begin
                        dbz_pend           <= 1'b0;
                        Quotient_Out       <= '1;
                        Remainder_Out      <= '0;
                        Divide_By_Zero_Out <= 1'b1;
                    end else begin
                        dvd_sr <= dvd_step;
                        quo_sr <= quo_step;
                        prem   <= prem_step;
                        iter   <= iter + 3'd1;
                        if (iter == LAST_ITER) begin
                            Quotient_Out       <= quo_step;
                            Remainder_Out      <= prem_step[3:0];
                            Divide_By_Zero_Out <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
